// File: rtl/arm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared definitions for the multicycle ARMv4-subset control unit:
//   state_t  - FSM states of the control sequencer
//   OP_*     - instruction class (Instr[27:26])
//   CMD_*    - data-processing command (funct[4:1])
//   ALU_*    - ALUControl codes (zero-extended to the port width)
//   cond_t   - ARM condition field encodings EQ..AL plus the reserved 1111
// Helper functions decode the command field into support / ALU code / C,V
// update behaviour.
// ---------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_ORR = 2'd3;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        logic ok;
        ok = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP) ||
             (cmd == CMD_AND) || (cmd == CMD_ORR);
        return ok;
    endfunction

    function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
        logic [1:0] code;
        case (cmd)
            CMD_SUB, CMD_CMP: code = ALU_SUB;
            CMD_AND:          code = ALU_AND;
            CMD_ORR:          code = ALU_ORR;
            default:          code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Logical ops leave C and V untouched; only arithmetic ops produce them.
    function automatic logic cmd_sets_cv(input logic [3:0] cmd);
        logic sets;
        sets = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
        return sets;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_cond_check.sv
// ---------------------------------------------------------------------------
// cond_check
// Combinational ARM condition evaluation.
//   cond_i  [3:0]  condition field Instr[31:28]
//   flags_i [3:0]  {N,Z,C,V} flag register
//   ok_o           1 when the instruction should execute (1111 never does)
// ---------------------------------------------------------------------------
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       ok_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    // NOTE: combinational blocks use blocking '=' and give every output a
    //       default first, so no path can leave it unassigned (no latch).
    always_comb begin
        ok_o = 1'b0;
        case (cond_t'(cond_i))
            COND_EQ: ok_o = z;
            COND_NE: ok_o = ~z;
            COND_CS: ok_o = c;
            COND_CC: ok_o = ~c;
            COND_MI: ok_o = n;
            COND_PL: ok_o = ~n;
            COND_VS: ok_o = v;
            COND_VC: ok_o = ~v;
            COND_HI: ok_o = c & ~z;
            COND_LS: ok_o = ~c | z;
            COND_GE: ok_o = (n == v);
            COND_LT: ok_o = (n != v);
            COND_GT: ok_o = ~z & (n == v);
            COND_LE: ok_o = z | (n != v);
            COND_AL: ok_o = 1'b1;
            default: ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// FSM sequencer for a multicycle ARMv4-subset datapath sharing one memory and
// one ALU. Holds the NZCV flag register, evaluates the condition field once
// per instruction in DECODE and drives all datapath muxes and enables.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   Instr       latched instruction bits [31:12]
//   ALUFlags    {N,Z,C,V} from the ALU in the current cycle
//   MemReady    memory completes its access this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite  write strobes (0 during reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
//               datapath mux selects and ALU operation
//   Undef       one-cycle pulse in DECODE for an undefined instruction
// ---------------------------------------------------------------------------
module multicycle_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W     = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:12]         Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Undef
);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ok_q, cond_ok_d;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       i_bit, s_bit, l_bit;
    logic       is_cmp;
    logic       undef_op;
    logic       mem_rdy;
    logic       cond_pass;
    logic       unused_rn;

    assign op     = Instr[27:26];
    assign funct  = Instr[25:20];
    assign cmd    = funct[4:1];
    assign i_bit  = funct[5];
    assign s_bit  = funct[0];
    assign l_bit  = funct[0];
    assign rd     = Instr[15:12];
    assign is_cmp = (cmd == CMD_CMP);

    // Rn is routed straight to the register file by the datapath.
    assign unused_rn = ^Instr[19:16];

    assign undef_op = (op == OP_UND) || ((op == OP_DP) && !cmd_supported(cmd));
    assign mem_rdy  = MEM_HANDSHAKE ? MemReady : 1'b1;

    cond_check u_cond_check (
        .cond_i  (Instr[31:28]),
        .flags_i (flags_q),
        .ok_o    (cond_pass)
    );

    // NOTE: state is updated only with non-blocking '<=' so every register
    //       samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            flags_q   <= 4'b0000;
            cond_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        cond_ok_d = cond_ok_q;
        case (state_q)
            FETCH: begin
                if (mem_rdy) state_d = DECODE;
            end
            DECODE: begin
                cond_ok_d = cond_pass;
                if (!cond_pass || undef_op) begin
                    state_d = FETCH;
                end else begin
                    case (op)
                        OP_MEM:  state_d = MEMADR;
                        OP_DP:   state_d = i_bit ? EXECI : EXECR;
                        OP_BR:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR: state_d = l_bit ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_rdy) state_d = MEMWB;
            end
            MEMWR: begin
                if (mem_rdy) state_d = FETCH;
            end
            EXECR, EXECI: begin
                state_d = ALUWB;
                // CMP updates flags even without S; C/V only come from add/sub.
                if (cond_ok_q && (s_bit || is_cmp)) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (cmd_sets_cv(cmd)) flags_d[1:0] = ALUFlags[1:0];
                end
            end
            MEMWB, ALUWB, BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ImmSrc     = op;
        RegSrc     = 2'b00;
        RegWrite   = 1'b0;
        ALUControl = ALUCTRL_W'(ALU_ADD);
        Undef      = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_rdy;
                PCWrite   = mem_rdy;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                RegSrc[0] = 1'b1;
                RegSrc[1] = (op == OP_MEM) && !l_bit;
                Undef     = undef_op;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ok_q;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ok_q;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl = ALUCTRL_W'(cmd_alu(cmd));
            end
            ALUWB: begin
                RegWrite = cond_ok_q && !is_cmp;
                PCWrite  = cond_ok_q && !is_cmp && (rd == 4'd15);
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                RegSrc[0] = 1'b1;
                PCWrite   = cond_ok_q;
            end
            default: ;
        endcase
        // Reset aborts whatever is in flight without letting a write escape.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Instruction-level reference model: for each instruction the bench works out
// which execution phases it goes through (from cond, flags, op and cmd), what
// the ALU flags are from real 32-bit arithmetic on random operands, and the
// control vector expected in each cycle. Directed cases first, then random.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:12]  Instr;
    logic [3:0]    ALUFlags;
    logic          MemReady;
    logic          PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, Undef;
    logic [1:0]    ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]    ALUControl;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALUCTRL_W(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl),
        .Undef      (Undef)
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic       rw;
        logic [3:0] alu;
        logic       undef;
    } ctl_t;

    ctl_t obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegSrc, RegWrite, ALUControl, Undef};

    int         checks = 0;
    int         errors = 0;
    int         n_instr = 0;
    logic [3:0] m_flags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven on the falling edge; outputs are compared 1ns later.
    task automatic step(input string tag, input ctl_t e, input logic rdy);
        MemReady = rdy;
        #1;
        check($sformatf("%s#%0d", tag, n_instr), 32'(obs), 32'(e));
        @(negedge clk);
    endtask

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = cy;
            4'd3:    r = !cy;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = cy && !z;
            4'd9:    r = !cy || z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z && (n == v);
            4'd13:   r = z || (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic ctl_t blank(input logic [1:0] op);
        ctl_t e;
        e     = '0;
        e.imm = op;
        return e;
    endfunction

    // Runs one instruction through fetch/decode and, when it executes, its
    // remaining phases. fstall/mstall are MemReady-low cycles in fetch and
    // in the data access. When rst_in_wr is set (store only), reset is raised
    // in the last write wait cycle instead of completing the access.
    task automatic run_instr(input logic [31:12] ins, input int fstall, input int mstall,
                             input logic [31:0] a, input logic [31:0] b, input bit rst_in_wr);
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [3:0]  cmd;
        logic        pass, und, cmp, n, z, c, v;
        logic [3:0]  alu;
        logic [32:0] r;
        ctl_t        e;
        n_instr++;
        op       = ins[27:26];
        fn       = ins[25:20];
        cmd      = fn[4:1];
        Instr    = ins;
        ALUFlags = 4'($urandom);

        e      = blank(op);
        e.srca = 1'b1;
        e.srcb = 2'b10;
        e.res  = 2'b10;
        for (int k = 0; k < fstall; k++) step("fetch_wait", e, 1'b0);
        e.pcw = 1'b1;
        e.irw = 1'b1;
        step("fetch", e, 1'b1);

        pass = cond_pass(ins[31:28], m_flags);
        und  = (op == 2'b11) ||
               (op == 2'b00 && !(cmd inside {4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100}));
        e        = blank(op);
        e.srca   = 1'b1;
        e.srcb   = 2'b10;
        e.regsrc = {(op == 2'b01) && !fn[0], 1'b1};
        e.undef  = und;
        step("decode", e, 1'($urandom));
        if (!pass || und) return;

        if (op == 2'b10) begin
            e        = blank(op);
            e.srcb   = 2'b01;
            e.res    = 2'b10;
            e.pcw    = 1'b1;
            e.regsrc = 2'b01;
            step("branch", e, 1'($urandom));
        end else if (op == 2'b01) begin
            e      = blank(op);
            e.srcb = 2'b01;
            step("memadr", e, 1'($urandom));
            e     = blank(op);
            e.adr = 1'b1;
            if (fn[0]) begin
                for (int k = 0; k < mstall; k++) step("memrd_wait", e, 1'b0);
                step("memrd", e, 1'b1);
                e     = blank(op);
                e.res = 2'b01;
                e.rw  = 1'b1;
                step("memwb", e, 1'($urandom));
            end else begin
                e.mw = 1'b1;
                for (int k = 0; k < mstall; k++) step("memwr_wait", e, 1'b0);
                if (rst_in_wr) begin
                    reset = 1'b1;
                    e.mw  = 1'b0;
                    step("memwr_rst", e, 1'b0);
                    reset   = 1'b0;
                    m_flags = 4'b0000;
                end else begin
                    step("memwr", e, 1'b1);
                end
            end
        end else begin
            cmp = (cmd == 4'b1010);
            case (cmd)
                4'b0100: begin
                    alu = 4'd0;
                    r   = {1'b0, a} + {1'b0, b};
                    c   = r[32];
                    v   = (a[31] == b[31]) && (r[31] != a[31]);
                end
                4'b0010, 4'b1010: begin
                    alu = 4'd1;
                    r   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                    c   = r[32];
                    v   = (a[31] != b[31]) && (r[31] != a[31]);
                end
                4'b0000: begin
                    alu = 4'd2;
                    r   = {1'b0, a & b};
                    c   = 1'($urandom);
                    v   = 1'($urandom);
                end
                default: begin
                    alu = 4'd3;
                    r   = {1'b0, a | b};
                    c   = 1'($urandom);
                    v   = 1'($urandom);
                end
            endcase
            n        = r[31];
            z        = (r[31:0] == 32'd0);
            ALUFlags = {n, z, c, v};
            e        = blank(op);
            e.srcb   = fn[5] ? 2'b01 : 2'b00;
            e.alu    = alu;
            step("exec", e, 1'($urandom));
            if (fn[0] || cmp) begin
                m_flags[3:2] = {n, z};
                if (alu <= 4'd1) m_flags[1:0] = {c, v};
            end
            ALUFlags = 4'($urandom);
            e        = blank(op);
            e.rw     = !cmp;
            e.pcw    = !cmp && (ins[15:12] == 4'd15);
            step("aluwb", e, 1'($urandom));
        end
    endtask

    function automatic logic [31:12] rand_instr();
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [3:0]  cmds [5];
        int          sel;
        cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100};
        cond = ($urandom_range(3, 0) == 0) ? 4'd14 : 4'($urandom);
        sel  = $urandom_range(9, 0);
        op   = (sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
        fn   = 6'($urandom);
        if (op == 2'b00 && $urandom_range(9, 0) != 0) fn[4:1] = cmds[$urandom_range(4, 0)];
        return {cond, op, fn, 4'($urandom), 4'($urandom)};
    endfunction

    initial begin
        ctl_t e;
        reset    = 1'b1;
        Instr    = 20'hE2821;
        ALUFlags = 4'b0000;
        MemReady = 1'b1;
        m_flags  = 4'b0000;
        @(negedge clk);

        // Held in reset: FETCH selects but no write strobes even with MemReady.
        e      = blank(2'b00);
        e.srca = 1'b1;
        e.srcb = 2'b10;
        e.res  = 2'b10;
        step("reset_fetch", e, 1'b1);
        step("reset_fetch", e, 1'b1);
        reset = 1'b0;

        run_instr(20'hE2821, 0, 0, 32'd7, 32'd5, 1'b0);            // ADD R1,R2,#5
        run_instr(20'hE0500, 1, 0, 32'h1234, 32'h1234, 1'b0);      // SUBS R0,R0,R0 -> Z=1
        run_instr(20'h02811, 0, 0, 32'd1, 32'd1, 1'b0);            // ADDEQ executes
        run_instr(20'h12811, 0, 0, 32'd1, 32'd1, 1'b0);            // ADDNE skipped
        run_instr(20'hE5912, 0, 3, 32'd0, 32'd4, 1'b0);            // LDR, 3 wait states
        run_instr(20'hEA000, 2, 0, 32'd0, 32'd0, 1'b0);            // B
        run_instr(20'hE282F, 0, 0, 32'd8, 32'd5, 1'b0);            // ADD PC -> PCWrite
        run_instr(20'hE1500, 0, 0, 32'd3, 32'd9, 1'b0);            // CMP -> N=1,C=0
        run_instr(20'h32811, 0, 0, 32'd1, 32'd1, 1'b0);            // ADDCC executes
        run_instr(20'hEC000, 0, 0, 32'd0, 32'd0, 1'b0);            // op=11 undefined
        run_instr(20'hE0200, 0, 0, 32'd0, 32'd0, 1'b0);            // EOR unsupported
        run_instr(20'hE5812, 0, 2, 32'd0, 32'd4, 1'b1);            // STR, reset in MEMWR
        run_instr(20'h42811, 0, 0, 32'd1, 32'd1, 1'b0);            // ADDMI skipped: N cleared
        run_instr(20'h52811, 0, 0, 32'd1, 32'd1, 1'b0);            // ADDPL executes
        run_instr(20'hF2811, 0, 0, 32'd1, 32'd1, 1'b0);            // cond 1111 never runs

        for (int i = 0; i < 400; i++) begin
            run_instr(rand_instr(), $urandom_range(2, 0), $urandom_range(3, 0),
                      $urandom, ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
